// File: rtl/datamem_dump_reader_if.sv
// datamem_dump_reader_if: control, memory read port and output stream of the dump reader.
interface datamem_dump_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [ADDR_W-1:0] read_select;
    logic [DATA_W-1:0] data_memory_output;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    modport master (
        output start, start_addr, len, abort, data_memory_output, out_ready,
        input  read_select, out_valid, out_data, out_addr, busy, done
    );
    modport slave (
        input  start, start_addr, len, abort, data_memory_output, out_ready,
        output read_select, out_valid, out_data, out_addr, busy, done
    );
endinterface

// File: rtl/datamem_dump_reader.sv
// datamem_dump_reader: walks an address range through the data memory's registered read port
// and streams each byte out over valid/ready.
module datamem_dump_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic                 clock,
    input logic                 reset,
    datamem_dump_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, SEND} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST  = {{ADDR_W{1'b0}}, 1'b1};
    state_t            state_q, state_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] oa_q, oa_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              ov_q, ov_d;
    logic              done_q, done_d;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rs_d    = rs_q;
        oa_d    = oa_q;
        od_d    = od_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        // abort outranks acceptance: a word on the bus at the abort edge is dropped
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            ov_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    rem_d   = bus.len > DEPTH ? DEPTH : bus.len;
                    rs_d    = bus.start_addr;
                    state_d = bus.len == '0 ? IDLE : ISSUE;
                    done_d  = bus.len == '0;
                end
                ISSUE: state_d = CAPTURE;
                CAPTURE: begin
                    od_d    = bus.data_memory_output;
                    oa_d    = rs_q;
                    ov_d    = 1'b1;
                    state_d = SEND;
                end
                SEND: if (bus.out_ready) begin
                    rem_d   = rem_q - LAST;
                    ov_d    = 1'b0;
                    done_d  = rem_q == LAST;
                    state_d = rem_q == LAST ? IDLE : ISSUE;
                    rs_d    = rem_q == LAST ? rs_q : rs_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            rs_q    <= '0;
            oa_q    <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            rs_q    <= rs_d;
            oa_q    <= oa_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            done_q  <= done_d;
        end
    end
    assign bus.read_select = rs_q;
    assign bus.out_valid   = ov_q;
    assign bus.out_data    = od_q;
    assign bus.out_addr    = oa_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
endmodule

// File: doc/datamem_dump_reader.md
Name: datamem_dump_reader

Overview:
- Read-side sequencer for the 16 x 8 data memory: walks a contiguous address range through the memory's registered read port and streams each byte out over a valid/ready handshake.
- Sits beside the data memory and shares its read_select/data_memory_output pins; used for debug dump to the host/display path and memory-contents checks after program runs.
- Never drives the write port.

Parameters:
- ADDR_W, 4, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data word width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- start_addr  in  ADDR_W  first address of the dump.
- len  in  ADDR_W+1  number of words to dump, 0..16; values above 16 are treated as 16.
- abort  in  1  cancels an active dump.
- read_select  out  ADDR_W  registered address to the data memory read port.
- data_memory_output  in  DATA_W  registered read data from the data memory.
- out_valid  out  1  out_data/out_addr hold a word.
- out_ready  in  1  consumer accepts the word when out_valid=1 at a rising edge.
- out_data  out  DATA_W  captured word.
- out_addr  out  ADDR_W  address out_data was read from.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after a dump completes normally.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - read_select, out_data, out_addr = 0.
  - out_valid, busy, done = 0.
  - Internal remaining count and address = 0.
- Memory timing contract: the memory samples read_select at edge N; data_memory_output is valid during the cycle after edge N.
- States:
  - IDLE:
    - done=0 except for the pulse cycle.
    - On start=1: latch remaining = min(len,16) and read_select = start_addr.
    - If len=0: stay in IDLE and pulse done next cycle; no words emitted.
    - Otherwise go to ISSUE.
  - ISSUE: read_select stable for one cycle; memory samples it at the end of this cycle; go to CAPTURE.
  - CAPTURE: register out_data = data_memory_output, out_addr = read_select, out_valid=1 at the end of this cycle; go to SEND.
  - SEND:
    - out_valid=1; out_data and out_addr are held stable until accepted.
    - On out_ready=1: remaining decrements and out_valid drops at that edge.
    - If remaining reaches 0: go to IDLE with done=1 for one cycle.
    - Otherwise: read_select = read_select+1 (mod 2**ADDR_W) and go to ISSUE.
- Latency:
  - Start edge to first out_valid = 3 edges.
  - Steady state with out_ready held high = 3 cycles per word.
- Wrap-around: the address increments modulo 16, e.g. start_addr=14, len=4 reads 14,15,0,1.
- start while busy: ignored; it neither restarts nor queues.
- abort=1 in any non-IDLE state:
  - Next edge: state=IDLE, out_valid=0, done stays 0, read_select holds its value.
  - abort has priority over out_ready acceptance on the same edge: the word is treated as not accepted.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins and nothing starts.
- Concurrent memory writes: the word returned is the memory contents at the ISSUE-end edge. No coherence guarantee beyond that.
- Reset mid-dump: immediate return to reset values, no done pulse.

Test Plan:
- Preload mem[i]=8'h10+i, start_addr=0, len=16, out_ready=1 -> 16 words 8'h10..8'h1F with out_addr 0..15, one word per 3 cycles, done pulse one cycle after the last acceptance, busy low afterwards.
- start_addr=14, len=4 -> out_addr sequence 14,15,0,1 with matching data; done asserted once.
- len=3, out_ready low for 5 cycles on the second word -> out_valid, out_data and out_addr held constant for those cycles; exactly 3 words transferred, no duplicates or drops.
- len=0 -> no out_valid; done pulses once; busy stays 0.
- len=8, abort asserted during SEND of the third word with out_ready=1 -> word not accepted, out_valid=0 next cycle, no done, IDLE; an immediate new start with start_addr=5 emits address 5 first.
- Reset asserted mid-ISSUE, and a start pulse issued while busy -> outputs go to 0 asynchronously; the busy-time start produces no extra words.
